// File: rtl/reg_access_arbiter.sv
// rtl/reg_access_arbiter.sv - round-robin arbiter serialising single-word accesses to a shared register bank
// Three-phase sequencer (IDLE -> XFER -> RESP); every output comes straight from a flop.
module reg_access_arbiter #(
  parameter int NREQ  = 4,
  parameter int NREG  = 8,
  parameter int WIDTH = 62,
  parameter int AW    = 4
) (
  input  logic                  clk,
  input  logic                  reset_l,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       we,
  input  logic [NREQ*AW-1:0]    addr,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      rdata,
  output logic                  busy,
  output logic [2:0]            grant_id,
  output logic [15:0]           conflict_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       state;
  logic [2:0]       last_grant;
  logic [2:0]       cur_idx;
  logic             cur_we;
  logic [AW-1:0]    cur_addr;
  logic [WIDTH-1:0] cur_wdata;
  logic [WIDTH-1:0] resp_q;
  logic [15:0]      conflict_q;
  logic [WIDTH-1:0] bank [NREG];

  logic [2:0]       win_idx;
  logic             win_found;
  logic             sel_we;
  logic [AW-1:0]    sel_addr;
  logic [WIDTH-1:0] sel_wdata;
  logic [WIDTH-1:0] rd_val;
  logic             contended;

  assign conflict_count = conflict_q;
  assign contended      = ($countones(req) > 1);

  // Scan from the farthest offset down so the nearest requester after last_grant wins.
  always_comb begin
    win_idx   = last_grant;
    win_found = 1'b0;
    for (int off = NREQ; off >= 1; off--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && (i == (int'(last_grant) + off) % NREQ)) begin
          win_idx   = 3'(i);
          win_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (i == int'(win_idx)) begin
        sel_we    = we[i];
        sel_addr  = addr[i*AW +: AW];
        sel_wdata = wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  // Out-of-range addresses match no entry, so reads fall through to zero.
  always_comb begin
    rd_val = '0;
    for (int r = 0; r < NREG; r++) begin
      if (int'(cur_addr) == r) begin
        rd_val = bank[r];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state      <= ST_IDLE;
      ack        <= '0;
      rdata      <= '0;
      busy       <= 1'b0;
      conflict_q <= '0;
      last_grant <= 3'(NREQ - 1);
      grant_id   <= 3'(NREQ - 1);
      cur_idx    <= '0;
      cur_we     <= 1'b0;
      cur_addr   <= '0;
      cur_wdata  <= '0;
      resp_q     <= '0;
      for (int r = 0; r < NREG; r++) begin
        bank[r] <= '0;
      end
    end else begin
      ack   <= '0;
      rdata <= '0;
      case (state)
        ST_IDLE: begin
          if (contended && conflict_q != 16'hFFFF) begin
            conflict_q <= conflict_q + 16'd1;
          end
          if (win_found) begin
            cur_idx   <= win_idx;
            cur_we    <= sel_we;
            cur_addr  <= sel_addr;
            cur_wdata <= sel_wdata;
            grant_id  <= win_idx;
            busy      <= 1'b1;
            state     <= ST_XFER;
          end
        end
        ST_XFER: begin
          resp_q <= cur_we ? cur_wdata : rd_val;
          for (int r = 0; r < NREG; r++) begin
            if (cur_we && int'(cur_addr) == r) begin
              bank[r] <= cur_wdata;
            end
          end
          state <= ST_RESP;
        end
        ST_RESP: begin
          for (int i = 0; i < NREQ; i++) begin
            ack[i] <= (i == int'(cur_idx));
          end
          rdata      <= resp_q;
          last_grant <= cur_idx;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/reg_access_arbiter.md
Name: reg_access_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared bank of public read/write registers.
- Up to NREQ requesters issue single-word reads or writes to the bank, e.g. test-bench pokes, monitor logic, or counter updaters.
- The block serialises the accesses, returns read data with a one-cycle ack, and counts contended arbitration cycles for VPI inspection.

Parameters:
NREQ, 4, number of requesters (2..8)
NREG, 8, number of WIDTH-bit registers in the bank (1..16)
WIDTH, 62, register data width in bits
AW, 4, per-requester address width; must satisfy 2**AW >= NREG

Ports:
clk  input  1  single clock; all state updates on posedge clk
reset_l  input  1  asynchronous, active-low reset
req  input  NREQ  per-requester request; held high until ack
we  input  NREQ  per-requester write enable (1=write, 0=read); stable while req high
addr  input  NREQ*AW  per-requester register address; requester i occupies bits [i*AW +: AW]
wdata  input  NREQ*WIDTH  per-requester write data; requester i occupies bits [i*WIDTH +: WIDTH]
ack  output  NREQ  one-hot, one-cycle completion pulse
rdata  output  WIDTH  data for the acked access; valid only while ack is nonzero
busy  output  1  high in states XFER and RESP
grant_id  output  3  index of the current or last granted requester
conflict_count  output  16  saturating count of contended arbitration cycles

Behaviour:
- Reset (asynchronous, reset_l=0):
  - state=IDLE; ack=0; rdata=0; busy=0; conflict_count=0.
  - All bank registers=0.
  - last_grant=NREQ-1, so requester 0 wins the first contest.
  - grant_id=NREQ-1.
- FSM states: IDLE, XFER, RESP. All outputs are registered.
- IDLE:
  - If req != 0, select the winner as the first asserted req scanning last_grant+1, last_grant+2, ... modulo NREQ.
  - Latch the winner's index, we, addr and wdata; grant_id <= index; go to XFER.
  - If req == 0, stay in IDLE.
- XFER:
  - Write: bank[addr] <= wdata; the response value is wdata.
  - Read: the response value is bank[addr] (the pre-cycle value).
  - Go to RESP.
- RESP:
  - ack[index]=1 for exactly this cycle; rdata=response value; last_grant <= index; go to IDLE.
- Latency:
  - A request first seen in IDLE at posedge k is acked during the cycle following posedge k+2.
  - Peak throughput is one access per 3 cycles.
- Requester protocol:
  - Hold req, we, addr and wdata stable until ack.
  - Drop req in the cycle after ack, or keep it high to issue a new request.
  - A req still high in the IDLE cycle after RESP is arbitrated as a new request. Round-robin order already deprioritises that requester.
- Out-of-range address (addr >= NREG):
  - A write has no effect.
  - A read returns 0.
  - ack is still issued with normal latency.
- Deassertion of req before ack is a protocol violation. The block completes the latched access anyway and still pulses ack.
- conflict_count:
  - Increments by 1 on each IDLE cycle where two or more req bits are high.
  - Saturates at 16'hFFFF with no wrap.
  - Does not increment in XFER or RESP.
- rdata is 0 whenever ack == 0.
- Reset mid-operation (XFER or RESP): returns to the reset state immediately.
  - An in-flight write that had not reached the XFER edge is lost.
  - No ack is issued for an aborted access.
  - The bank is cleared regardless.
- Bank contents are visible only through reads; no direct output port.

Test Plan:
- Reset values:
  - Stimulus: hold reset_l=0 for 3 cycles, then release.
  - Required: ack=0, busy=0, conflict_count=0, grant_id=3; a read of addr 5 by requester 2 returns 0.
- Write then read, single requester:
  - Stimulus: requester 1 writes 62'h12819213_abd31a1c to addr 2.
  - Required: ack[1] pulses 2 cycles after req seen in IDLE, with rdata=wdata.
  - Stimulus: requester 3 then reads addr 2.
  - Required: rdata=62'h12819213_abd31a1c.
- Round-robin fairness:
  - Stimulus: all 4 requesters request continuously after reset.
  - Required: grant order is 0,1,2,3,0,1; each ack is spaced 3 cycles apart; conflict_count=6 after 6 grants.
- Saturation:
  - Stimulus: force contention for 70000 arbitration cycles.
  - Required: conflict_count stays at 16'hFFFF.
- Out-of-range:
  - Stimulus: NREG=8, write 62'h1c77bb9b_3784ea09 to addr 9.
  - Required: ack is issued; subsequent reads of addr 1 and addr 9 both return 0.
- Reset mid-XFER:
  - Stimulus: assert reset_l=0 during the XFER of a write to addr 0.
  - Required: no ack; after release, a read of addr 0 returns 0 and requester 0 wins the first contest.
